// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signals of apb_req_arbiter.
// master: the arbiter's view; slave: the environment (requesters and APB completer).
interface apb_req_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*3-1:0]  req_prot;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;

    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [2:0]         pprot;
    logic               pready;
    logic               pslverr;
    logic [DW-1:0]      prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_prot,
        input  pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pprot
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_prot,
        output pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pprot
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB completer between NREQ requesters; all outputs registered.
// Optional ACCESS timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    apb_req_arbiter_if.master bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb_req_arbiter: unsupported NREQ/TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [2:0]      pprot_q, pprot_d;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   nxt_ptr;
    logic [31:0]     cand;
    logic            accept;
    logic            tmo_hit;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE && |req_ready_q) begin
            tmo_cnt_d = '0;
        end else if (state_q == ACCESS && !bus.pready) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // First requesting index at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NREQ;
            if (!gnt_found && bus.req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
        nxt_ptr = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // req_ready is registered, so a grant spends one cycle in IDLE with the
    // pulse asserted; that pulse is what moves IDLE on to SETUP.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pprot_d     = pprot_q;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_ready_q) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end else begin
                    accept = gnt_found;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d              = IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d            = bus.pslverr;
                    accept               = gnt_found;
                end else if (tmo_hit) begin
                    state_d              = IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    accept               = gnt_found;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        if (accept) begin
            req_ready_d[gnt_idx] = 1'b1;
            owner_d              = gnt_idx;
            rr_ptr_d             = nxt_ptr;
            pwrite_d             = bus.req_write[gnt_idx];
            paddr_d              = bus.req_addr[gnt_idx*AW +: AW];
            pwdata_d             = bus.req_wdata[gnt_idx*DW +: DW];
            pprot_d              = bus.req_prot[gnt_idx*3 +: 3];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pprot_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pprot_q     <= pprot_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pprot     = pprot_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(req_ready_q));
    a_rsp_onehot:   assert property (@(posedge clk) disable iff (!resetn) $onehot0(rsp_valid_q));
    a_pen_psel:     assert property (@(posedge clk) disable iff (!resetn) penable_q |-> psel_q);
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: single transfers, wait states, round-robin,
// slave error, reset mid-ACCESS and (with APB_ARB_TIMEOUT_EN) the ACCESS timeout.
module tb_apb_req_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic clk;
    logic resetn;

    apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    int unsigned sl_waits = 0;
    logic [DW-1:0] sl_rdata = '0;
    logic sl_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // APB completer: pready rises after sl_waits ACCESS cycles.
    initial begin
        int unsigned acc_cnt;
        acc_cnt     = 0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.psel && bus.penable) begin
                bus.pready = (acc_cnt == sl_waits);
                acc_cnt++;
            end else begin
                bus.pready = 1'b0;
                acc_cnt    = 0;
            end
            bus.prdata  = sl_rdata;
            bus.pslverr = sl_err && bus.pready;
        end
    end

    task automatic wait_grant(input int unsigned r, input string tag);
        bit seen;
        logic [NREQ-1:0] exp;
        seen = 1'b0;
        exp  = '0;
        exp[r] = 1'b1;
        for (int unsigned k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus.req_ready != '0) seen = 1'b1;
        end
        check({tag, "_grant"}, bus.req_ready, exp);
    endtask

    task automatic drive_req(input int unsigned r, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [2:0] pr);
        bus.req_write[r]           = wr;
        bus.req_addr[r*AW +: AW]   = a;
        bus.req_wdata[r*DW +: DW]  = wd;
        bus.req_prot[r*3 +: 3]     = pr;
        bus.req_valid[r]           = 1'b1;
    endtask

    task automatic xfer(input string tag, input int unsigned r, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [2:0] pr,
                        input int unsigned waits, input logic [DW-1:0] rd, input logic err);
        logic [NREQ-1:0] own;
        own    = '0;
        own[r] = 1'b1;
        sl_waits = waits;
        sl_rdata = rd;
        sl_err   = err;
        drive_req(r, wr, a, wd, pr);
        wait_grant(r, tag);
        check({tag, "_t0_psel"}, bus.psel, 1'b0);
        bus.req_valid[r] = 1'b0;
        tick();
        check({tag, "_setup"}, {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pprot},
              {1'b1, 1'b0, wr, a, pr});
        check({tag, "_setup_wdata"}, bus.pwdata, wd);
        for (int unsigned k = 0; k <= waits; k++) begin
            tick();
            check({tag, "_access"}, {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pprot},
                  {1'b1, 1'b1, wr, a, pr});
            check({tag, "_access_wdata"}, bus.pwdata, wd);
            check({tag, "_access_norsp"}, bus.rsp_valid, 2'b00);
        end
        tick();
        check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable},
              {own, err, 1'b0, 1'b0});
        check({tag, "_rdata"}, bus.rsp_rdata, wr ? 32'h0 : rd);
        tick();
        check({tag, "_rsp_pulse"}, bus.rsp_valid, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_prot  = '0;
        tick();
        tick();
        check("reset_ctl", {bus.psel, bus.penable, bus.pwrite, bus.req_ready, bus.rsp_valid, bus.rsp_err},
              '0);
        check("reset_data", {bus.paddr, bus.pprot, bus.pwdata, bus.rsp_rdata}, '0);
        resetn = 1'b1;
        tick();

        // Single read, zero waits
        xfer("rd0", 0, 1'b0, 5'd5, 32'h0, 3'd0, 0, 32'hDEADBEEF, 1'b0);
        // Write with 3 wait states (rr_ptr now 1)
        xfer("wr1", 1, 1'b1, 5'd31, 32'h12345678, 3'd2, 3, 32'hFFFF_FFFF, 1'b0);

        // Round-robin, both held valid (rr_ptr back at 0)
        sl_waits = 0;
        sl_rdata = 32'h1111_2222;
        sl_err   = 1'b0;
        drive_req(0, 1'b0, 5'd1, 32'h0, 3'd0);
        drive_req(1, 1'b0, 5'd2, 32'h0, 3'd0);
        wait_grant(0, "rr0");
        for (int unsigned k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("rr%0d_mid1", k), bus.req_ready, 2'b00);
            tick();
            check($sformatf("rr%0d_mid2", k), bus.req_ready, 2'b00);
            tick();
            check($sformatf("rr%0d_grant", k), bus.req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            check($sformatf("rr%0d_rsp", k), bus.rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
            check($sformatf("rr%0d_rdata", k), bus.rsp_rdata, 32'h1111_2222);
        end
        bus.req_valid = '0;
        repeat (3) tick();
        check("rr_last_rsp", {bus.rsp_valid, bus.req_ready}, 4'b1000);
        tick();

        // Slave error, then a clean transfer
        xfer("err0", 0, 1'b0, 5'd3, 32'h0, 3'd1, 0, 32'hA5A5_0003, 1'b1);
        xfer("ok1", 1, 1'b0, 5'd7, 32'h0, 3'd0, 1, 32'h0BAD_F00D, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never responds: abort after 16 ACCESS cycles
        sl_waits = 1000;
        sl_rdata = 32'hCAFE_CAFE;
        drive_req(0, 1'b0, 5'd4, 32'h0, 3'd0);
        wait_grant(0, "tmo");
        bus.req_valid[0] = 1'b0;
        tick();
        for (int unsigned k = 0; k < 16; k++) begin
            tick();
            check($sformatf("tmo_access%0d", k), {bus.psel, bus.penable, bus.rsp_valid}, 4'b1100);
        end
        tick();
        check("tmo_end", {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable}, 5'b01100);
        check("tmo_rdata", bus.rsp_rdata, 32'h0);
        tick();
`endif

        // Reset during an ACCESS wait state (rr_ptr becomes 1 before reset)
        sl_waits = 1000;
        drive_req(0, 1'b0, 5'd9, 32'h0, 3'd0);
        wait_grant(0, "rst");
        bus.req_valid[0] = 1'b0;
        repeat (5) tick();
        check("rst_pre", {bus.psel, bus.penable}, 2'b11);
        resetn = 1'b0;
        #1;
        check("rst_async_ctl", {bus.psel, bus.penable, bus.pwrite, bus.req_ready, bus.rsp_valid}, '0);
        check("rst_async_addr", bus.paddr, '0);
        tick();
        resetn   = 1'b1;
        sl_waits = 0;
        sl_rdata = 32'h5555_AAAA;
        for (int unsigned k = 0; k < 6; k++) begin
            tick();
            check("rst_quiet", {bus.rsp_valid, bus.psel}, 3'b000);
        end
        drive_req(0, 1'b0, 5'd10, 32'h0, 3'd0);
        drive_req(1, 1'b0, 5'd11, 32'h0, 3'd0);
        wait_grant(0, "rst_after");
        bus.req_valid = '0;
        tick();
        check("rst_after_setup", {bus.psel, bus.penable, bus.paddr}, {2'b10, 5'd10});
        repeat (2) tick();
        check("rst_after_rsp", {bus.rsp_valid, bus.rsp_err}, 3'b010);
        check("rst_after_rdata", bus.rsp_rdata, 32'h5555_AAAA);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
